// File: rtl/softspi_slave_pkg.sv
// softspi_slave_pkg: shared byte type and bit-counter width for the SPI slave.
// No ports; imported by softspi_slave and softspi_slave_sync_edge.
package softspi_slave_pkg;
    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;
    typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/softspi_slave_sync_edge.sv
// softspi_slave_sync_edge: 3-flop synchronizer with one-cycle rise/fall strobes.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (flops load INIT)
//   d     in  asynchronous input pin
//   rise  out one-cycle strobe on a synchronized 0->1 transition
//   fall  out one-cycle strobe on a synchronized 1->0 transition
module softspi_slave_sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= {3{INIT}};
        else        sr <= {sr[1:0], d};
    end

    // sr[1] is the synchronized level; sr[2] is its previous value.
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/softspi_slave.sv
// softspi_slave: oversampled SPI mode-0 byte slave with a one-entry tx holding register.
// Ports:
//   sys_clk, sys_rst_n          system clock, asynchronous active-low reset
//   spi_SCLK, spi_SS_n, spi_MOSI asynchronous SPI inputs from the master
//   spi_MISO, spi_MISO_oe        slave data out (tx_shift[7]) and its output enable
//   tx_data, tx_valid, tx_ready  CPU write handshake into the holding register
//   rx_data, rx_valid            last received byte and its one-cycle strobe
//   tx_underrun                  strobe when DEFAULT_TX was loaded from an empty register
//   busy                         high while the slave is selected
module softspi_slave
    import softspi_slave_pkg::*;
#(
    parameter byte_t DEFAULT_TX = 8'hFF
) (
    input  logic  sys_clk,
    input  logic  sys_rst_n,
    input  logic  spi_SCLK,
    input  logic  spi_SS_n,
    input  logic  spi_MOSI,
    output logic  spi_MISO,
    output logic  spi_MISO_oe,
    input  byte_t tx_data,
    input  logic  tx_valid,
    output logic  tx_ready,
    output byte_t rx_data,
    output logic  rx_valid,
    output logic  tx_underrun,
    output logic  busy
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic                 sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [1:0]           mosi_sr;
    logic [0:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 byte_done;
    logic [BYTE_W-2:0]    rx_shift;
    byte_t                tx_shift, hold;
    logic                 hold_full;
    logic                 start, rx_edge, tx_edge, load, shift, tx_write;

    softspi_slave_sync_edge #(.INIT(1'b0)) u_sclk (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(spi_SCLK), .rise(sclk_rise), .fall(sclk_fall)
    );

    softspi_slave_sync_edge #(.INIT(1'b1)) u_ss (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(spi_SS_n), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) mosi_sr <= 2'b00;
        else            mosi_sr <= {mosi_sr[0], spi_MOSI};
    end

    // ss_rise outranks SCLK edges in ACTIVE so an aborted byte never loads or shifts.
    assign start    = (state == IDLE) & ss_fall;
    assign rx_edge  = (state == ACTIVE) & ~ss_rise & sclk_rise;
    assign tx_edge  = (state == ACTIVE) & ~ss_rise & sclk_fall;
    assign load     = start | (tx_edge & byte_done);
    assign shift    = tx_edge & ~byte_done;
    assign tx_write = tx_valid & tx_ready;

    // A load looks at hold_full before any same-cycle write, so that write stays for the next load.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= DEFAULT_TX;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load & ~hold_full;
            if (tx_write)  {hold, hold_full} <= {tx_data, 1'b1};
            else if (load) hold_full <= 1'b0;
            if (load)       tx_shift <= hold_full ? hold : DEFAULT_TX;
            else if (shift) tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start || (state == ACTIVE && ss_rise)) begin
                state     <= start ? ACTIVE : IDLE;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else if (rx_edge) begin
                rx_shift <= {rx_shift[BYTE_W-3:0], mosi_sr[1]};
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                    rx_data   <= {rx_shift, mosi_sr[1]};
                    rx_valid  <= 1'b1;
                    byte_done <= 1'b1;
                end
            end else if (tx_edge && byte_done) begin
                byte_done <= 1'b0;
            end
        end
    end

    // The third SS_n flop lags the synchronized level by one cycle, so ACTIVE tracks "selected".
    assign busy        = (state == ACTIVE);
    assign spi_MISO_oe = (state == ACTIVE);
    assign spi_MISO    = tx_shift[BYTE_W-1];
    assign tx_ready    = ~hold_full;
endmodule
